// File: rtl/hop_pkg.sv
// hop_pkg: shared run states and constants for the hop-chain checker and benchmarks.
package hop_pkg;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
   localparam int HOPS_DEF = 6;
   localparam int TIMEOUT_DEF = 15;
   function automatic int lat_none(input int cw);
      return (1 << cw) - 1;
   endfunction
endpackage

// File: rtl/hop_lane_monitor.sv
// hop_lane_monitor: per-lane arrival latch, pulse-width check and sticky fail flag.
module hop_lane_monitor
   import hop_pkg::*;
#(
   parameter int HOPS = HOPS_DEF,
   parameter int CW = 5
)(
   input  logic          clock0,
   input  logic          rst1,
   input  logic          clr,
   input  logic          active,
   input  logic          finish,
   input  logic          en,
   input  logic          lane_in,
   input  logic [CW-1:0] cnt,
   output logic [CW-1:0] lat_q,
   output logic          arrived,
   output logic          fail_q,
   output logic          fail_d
);
   localparam logic [CW-1:0] LAT_NONE = CW'(lat_none(CW));
   logic [CW-1:0] lat_d;
   logic          hit;
   // any high after the first arrival violates the single-cycle width
   always_comb begin
      hit = active & en & lane_in;
      arrived = lat_q != LAT_NONE;
      lat_d = clr ? LAT_NONE : (hit & ~arrived) ? cnt : lat_q;
      fail_d = clr ? 1'b0 : fail_q | (hit & (arrived | (cnt != CW'(HOPS)))) | (finish & en & (lat_d == LAT_NONE));
   end
   always_ff @(posedge clock0) begin
      if (rst1) begin
         lat_q <= LAT_NONE;
         fail_q <= 1'b0;
      end else begin
         lat_q <= lat_d;
         fail_q <= fail_d;
      end
   end
endmodule

// File: rtl/hop_chain_checker.sv
// hop_chain_checker: launches one pulse per enabled lane and grades each chain's
// arrival latency and pulse width.
module hop_chain_checker
   import hop_pkg::*;
#(
   parameter int LANES = 4,
   parameter int HOPS = HOPS_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   localparam int CW = $clog2(TIMEOUT + 2)
)(
   input  logic                clock0,
   input  logic                rst1,
   input  logic                go,
   input  logic [LANES-1:0]    lane_en,
   input  logic [LANES-1:0]    lane_in,
   output logic [LANES-1:0]    start_out,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [LANES-1:0]    fail_mask,
   output logic [LANES*CW-1:0] lat_out
);
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [LANES-1:0] en_q, en_d;
   logic             pass_q, pass_d;
   logic [LANES-1:0] arrived, fail_q, fail_d;
   logic             accept, active, finish;
   // arrived is registered, so all-arrived means every width check cycle has been seen
   always_comb begin
      accept = (state_q == IDLE) & go;
      active = (state_q == LAUNCH) | (state_q == WAIT);
      finish = (state_q == WAIT) & (&(arrived | ~en_q) | (cnt_q == CW'(TIMEOUT)));
      state_d = state_q;
      cnt_d = cnt_q;
      en_d = en_q;
      pass_d = pass_q;
      case (state_q)
         IDLE: if (go) begin
            en_d = lane_en;
            cnt_d = '0;
            pass_d = lane_en == '0;
            state_d = (lane_en == '0) ? DONE : LAUNCH;
         end
         LAUNCH: begin
            cnt_d = CW'(1);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
            if (finish) begin
               state_d = DONE;
               pass_d = ~|fail_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock0) begin
      if (rst1) begin
         state_q <= IDLE;
         cnt_q <= '0;
         en_q <= '0;
         pass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         en_q <= en_d;
         pass_q <= pass_d;
      end
   end
   assign start_out = (state_q == LAUNCH) ? en_q : '0;
   assign busy = active;
   assign done = state_q == DONE;
   assign pass = pass_q;
   assign fail_mask = fail_q;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      hop_lane_monitor #(.HOPS(HOPS), .CW(CW)) u_mon (
         .clock0 (clock0),
         .rst1   (rst1),
         .clr    (accept),
         .active (active),
         .finish (finish),
         .en     (en_q[i]),
         .lane_in(lane_in[i]),
         .cnt    (cnt_q),
         .lat_q  (lat_out[i*CW +: CW]),
         .arrived(arrived[i]),
         .fail_q (fail_q[i]),
         .fail_d (fail_d[i])
      );
   end
endmodule

// File: tb/tb_hop_chain_checker.sv
// tb_hop_chain_checker: emulated chains per lane, results graded by a timeline-level model.
module tb_hop_chain_checker;
   localparam int LANES = 4;
   localparam int HOPS = 6;
   localparam int TIMEOUT = 15;
   localparam int CW = $clog2(TIMEOUT + 2);
   localparam int MAXK = 40;

   logic clock0 = 1'b0, rst1 = 1'b1, go = 1'b0;
   logic [LANES-1:0] lane_en = '0, lane_in = '0;
   logic [LANES-1:0] start_out, fail_mask;
   logic busy, done, pass;
   logic [LANES*CW-1:0] lat_out;

   hop_chain_checker dut (
      .clock0(clock0), .rst1(rst1), .go(go), .lane_en(lane_en), .lane_in(lane_in),
      .start_out(start_out), .busy(busy), .done(done), .pass(pass),
      .fail_mask(fail_mask), .lat_out(lat_out)
   );

   always #5 clock0 = ~clock0;

   int n_checks = 0, n_fail = 0;
   int d[LANES], w[LANES], x[LANES];
   int obs_done_k, obs_so_cnt, obs_so_k, obs_busy_cnt;
   logic [LANES-1:0] obs_so_val, obs_fm;
   logic obs_pass, obs_done2;
   logic [LANES*CW-1:0] obs_lat;
   int exp_done_k;
   logic exp_pass;
   logic [LANES-1:0] exp_fm;
   logic [LANES*CW-1:0] exp_lat;

   // chain i: high for w cycles starting d cycles after launch (d=0 tied low), plus an optional glitch at x
   function automatic bit high(input int i, input int k);
      return (d[i] > 0 && k >= d[i] && k < d[i] + w[i]) || (x[i] > 0 && k == x[i]);
   endfunction

   task automatic set_chain(input int i, input int dd, input int ww, input int xx);
      d[i] = dd; w[i] = ww; x[i] = xx;
   endtask

   task automatic model(input logic [LANES-1:0] en);
      int a[LANES];
      int end_k;
      bit all;
      exp_fm = '0;
      exp_lat = '1;
      if (en == '0) begin
         exp_done_k = 0;
         exp_pass = 1'b1;
         return;
      end
      all = 1;
      end_k = 0;
      for (int i = 0; i < LANES; i++) begin
         a[i] = -1;
         if (en[i]) begin
            for (int k = 0; k <= TIMEOUT; k++) if (a[i] < 0 && high(i, k)) a[i] = k;
            if (a[i] < 0) all = 0;
            else if (a[i] + 1 > end_k) end_k = a[i] + 1;
         end
      end
      if (!all || end_k > TIMEOUT) end_k = TIMEOUT;
      for (int i = 0; i < LANES; i++) begin
         if (en[i]) begin
            if (a[i] < 0) exp_fm[i] = 1'b1;
            else begin
               exp_lat[i*CW +: CW] = CW'(a[i]);
               if (a[i] != HOPS) exp_fm[i] = 1'b1;
               for (int k = a[i] + 1; k <= end_k; k++) if (high(i, k)) exp_fm[i] = 1'b1;
            end
         end
      end
      exp_done_k = end_k + 1;
      exp_pass = exp_fm == '0;
   endtask

   // k counts cycles from the one after go is accepted (the launch cycle)
   task automatic run(input logic [LANES-1:0] en, input bit hold);
      @(negedge clock0);
      go = 1'b1;
      lane_en = en;
      @(posedge clock0);
      #1;
      if (!hold) go = 1'b0;
      obs_done_k = -1; obs_so_cnt = 0; obs_so_k = -1; obs_so_val = '0; obs_busy_cnt = 0;
      for (int k = 0; k < MAXK && obs_done_k < 0; k++) begin
         for (int i = 0; i < LANES; i++) lane_in[i] = high(i, k);
         @(negedge clock0);
         if (start_out != '0) begin
            if (obs_so_k < 0) obs_so_k = k;
            obs_so_cnt++;
            obs_so_val = start_out;
         end
         if (busy) obs_busy_cnt++;
         if (done) begin
            obs_done_k = k;
            obs_pass = pass;
            obs_fm = fail_mask;
            obs_lat = lat_out;
            go = 1'b0;
         end
         @(posedge clock0);
         #1;
      end
      lane_in = '0;
      go = 1'b0;
      @(negedge clock0);
      obs_done2 = done;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clock0);
      @(negedge clock0);
      n_checks++; if (start_out !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: start_out=%h busy=%b want 0 0", start_out, busy); end
      n_checks++; if (done !== 1'b0 || pass !== 1'b0) begin n_fail++; $display("FAIL reset_status: done=%b pass=%b want 0 0", done, pass); end
      n_checks++; if (fail_mask !== '0) begin n_fail++; $display("FAIL reset_fail_mask: got %h want 0", fail_mask); end
      n_checks++; if (lat_out !== {LANES*CW{1'b1}}) begin n_fail++; $display("FAIL reset_lat: got %h want all-ones", lat_out); end
      rst1 = 1'b0;
   endtask

   task automatic test_ideal();
      for (int i = 0; i < LANES; i++) set_chain(i, HOPS, 1, 0);
      model(4'hF);
      run(4'hF, 0);
      n_checks++; if (obs_done_k !== 8 || exp_done_k !== 8) begin n_fail++; $display("FAIL ideal_done_k: got %0d want 8", obs_done_k); end
      n_checks++; if (obs_so_cnt !== 1 || obs_so_val !== 4'hF || obs_so_k !== 0) begin n_fail++; $display("FAIL ideal_start: cnt=%0d val=%h k=%0d want 1 F 0", obs_so_cnt, obs_so_val, obs_so_k); end
      n_checks++; if (obs_pass !== 1'b1 || obs_fm !== 4'h0) begin n_fail++; $display("FAIL ideal_result: pass=%b fm=%h want 1 0", obs_pass, obs_fm); end
      n_checks++; if (obs_lat !== {LANES{CW'(HOPS)}}) begin n_fail++; $display("FAIL ideal_lat: got %h want %h", obs_lat, {LANES{CW'(HOPS)}}); end
      n_checks++; if (obs_busy_cnt !== 8 || obs_done2 !== 1'b0) begin n_fail++; $display("FAIL ideal_busy_done: busy_cycles=%0d done_after=%b want 8 0", obs_busy_cnt, obs_done2); end
   endtask

   task automatic test_slow_lane();
      for (int i = 0; i < LANES; i++) set_chain(i, HOPS, 1, 0);
      set_chain(2, HOPS + 1, 1, 0);
      model(4'hF);
      run(4'hF, 0);
      n_checks++; if (obs_lat[2*CW +: CW] !== CW'(7)) begin n_fail++; $display("FAIL slow_lat2: got %0d want 7", obs_lat[2*CW +: CW]); end
      n_checks++; if (obs_fm !== 4'b0100 || obs_pass !== 1'b0) begin n_fail++; $display("FAIL slow_result: fm=%b pass=%b want 0100 0", obs_fm, obs_pass); end
      n_checks++; if (obs_done_k !== exp_done_k) begin n_fail++; $display("FAIL slow_done_k: got %0d want %0d", obs_done_k, exp_done_k); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < LANES; i++) set_chain(i, HOPS, 1, 0);
      set_chain(1, 0, 1, 0);
      model(4'h3);
      run(4'h3, 0);
      n_checks++; if (obs_done_k !== TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_done_k: got %0d want %0d", obs_done_k, TIMEOUT + 1); end
      n_checks++; if (obs_lat[CW +: CW] !== {CW{1'b1}}) begin n_fail++; $display("FAIL timeout_lat1: got %h want all-ones", obs_lat[CW +: CW]); end
      n_checks++; if (obs_fm !== 4'b0010 || obs_pass !== 1'b0) begin n_fail++; $display("FAIL timeout_result: fm=%b pass=%b want 0010 0", obs_fm, obs_pass); end
      n_checks++; if (obs_so_val !== 4'h3 || obs_so_cnt !== 1) begin n_fail++; $display("FAIL timeout_start: val=%h cnt=%0d want 3 1", obs_so_val, obs_so_cnt); end
   endtask

   task automatic test_stretch();
      for (int i = 0; i < LANES; i++) set_chain(i, HOPS, 1, 0);
      set_chain(0, HOPS, 2, 0);
      set_chain(2, HOPS, 3, 0);
      set_chain(3, 0, 1, 0);
      model(4'h3);
      run(4'h3, 0);
      n_checks++; if (obs_lat[CW-1:0] !== CW'(HOPS)) begin n_fail++; $display("FAIL stretch_lat0: got %0d want %0d", obs_lat[CW-1:0], HOPS); end
      n_checks++; if (obs_fm !== 4'b0001 || obs_pass !== 1'b0) begin n_fail++; $display("FAIL stretch_result: fm=%b pass=%b want 0001 0", obs_fm, obs_pass); end
      n_checks++; if (obs_lat !== exp_lat || obs_done_k !== exp_done_k) begin n_fail++; $display("FAIL stretch_model: lat=%h k=%0d want %h %0d", obs_lat, obs_done_k, exp_lat, exp_done_k); end
   endtask

   task automatic test_no_lanes();
      for (int i = 0; i < LANES; i++) set_chain(i, HOPS, 1, 0);
      run(4'h0, 0);
      n_checks++; if (obs_done_k !== 0) begin n_fail++; $display("FAIL nolanes_done_k: got %0d want 0", obs_done_k); end
      n_checks++; if (obs_pass !== 1'b1 || obs_fm !== 4'h0) begin n_fail++; $display("FAIL nolanes_result: pass=%b fm=%h want 1 0", obs_pass, obs_fm); end
      n_checks++; if (obs_so_cnt !== 0 || obs_busy_cnt !== 0) begin n_fail++; $display("FAIL nolanes_activity: start_cycles=%0d busy_cycles=%0d want 0 0", obs_so_cnt, obs_busy_cnt); end
   endtask

   task automatic test_reset_mid();
      int dn;
      for (int i = 0; i < LANES; i++) set_chain(i, 3, 1, 0);
      set_chain(0, 2, 1, 0);
      @(negedge clock0);
      go = 1'b1;
      lane_en = 4'hF;
      @(posedge clock0);
      #1;
      go = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         for (int i = 0; i < LANES; i++) lane_in[i] = high(i, k);
         if (k < 3) begin
            @(posedge clock0);
            #1;
         end
      end
      rst1 = 1'b1;
      @(posedge clock0);
      #1;
      rst1 = 1'b0;
      lane_in = '0;
      @(negedge clock0);
      n_checks++; if (busy !== 1'b0 || start_out !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_ctrl: busy=%b start=%h done=%b want 0 0 0", busy, start_out, done); end
      n_checks++; if (lat_out !== {LANES*CW{1'b1}} || fail_mask !== '0) begin n_fail++; $display("FAIL midreset_state: lat=%h fm=%h want all-ones 0", lat_out, fail_mask); end
      dn = 0;
      repeat (20) begin
         @(negedge clock0);
         if (done || busy) dn++;
      end
      n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL midreset_idle: active cycles=%0d want 0", dn); end
      for (int i = 0; i < LANES; i++) set_chain(i, HOPS, 1, 0);
      model(4'hF);
      run(4'hF, 1);
      n_checks++; if (obs_done_k !== 8 || obs_pass !== 1'b1 || obs_fm !== 4'h0) begin n_fail++; $display("FAIL hold_go_result: k=%0d pass=%b fm=%h want 8 1 0", obs_done_k, obs_pass, obs_fm); end
      n_checks++; if (obs_so_cnt !== 1 || obs_busy_cnt !== 8) begin n_fail++; $display("FAIL hold_go_launch: start_cycles=%0d busy_cycles=%0d want 1 8", obs_so_cnt, obs_busy_cnt); end
   endtask

   task automatic test_random();
      logic [LANES-1:0] en;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < LANES; i++) begin
            int r;
            r = $urandom_range(0, 9);
            set_chain(i, r < 5 ? HOPS : r == 5 ? 0 : $urandom_range(1, 17),
                      $urandom_range(0, 3) == 0 ? 2 : 1,
                      $urandom_range(0, 4) == 0 ? $urandom_range(1, 18) : 0);
         end
         en = LANES'($urandom_range(0, 15));
         model(en);
         run(en, 0);
         n_checks++; if (obs_done_k !== exp_done_k) begin n_fail++; $display("FAIL rand%0d_done_k: en=%h got %0d want %0d", n, en, obs_done_k, exp_done_k); end
         n_checks++; if (obs_pass !== exp_pass || obs_fm !== exp_fm) begin n_fail++; $display("FAIL rand%0d_result: en=%h pass=%b fm=%b want %b %b", n, en, obs_pass, obs_fm, exp_pass, exp_fm); end
         n_checks++; if (obs_lat !== exp_lat) begin n_fail++; $display("FAIL rand%0d_lat: en=%h got %h want %h", n, en, obs_lat, exp_lat); end
         n_checks++; if (obs_so_val !== en || obs_so_cnt !== (en != 0 ? 1 : 0) || obs_busy_cnt !== (en != 0 ? exp_done_k : 0)) begin n_fail++; $display("FAIL rand%0d_activity: start=%h/%0d busy=%0d want %h", n, obs_so_val, obs_so_cnt, obs_busy_cnt, en); end
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_slow_lane();
      test_timeout();
      test_stretch();
      test_no_lanes();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
